// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter that shares the register_bank write port between NUM_REQ
// full-warp writeback sources, with a one-entry registered output stage.
module regbank_write_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int NUM_LANES = 8,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]             req_addr,
  input  logic [NUM_REQ*NUM_LANES-1:0]          req_mask,
  input  logic [NUM_REQ*NUM_LANES*DATA_W-1:0]   req_data,
  input  logic                                  wr_stall,
  output logic [NUM_LANES-1:0]                  write_en,
  output logic [ADDR_W-1:0]                     waddr,
  output logic [NUM_LANES*DATA_W-1:0]           wdata,
  output logic                                  pend_valid,
  output logic [ADDR_W-1:0]                     pend_addr,
  output logic [$clog2(NUM_REQ)-1:0]            grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int ROW_W = NUM_LANES * DATA_W;

  logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
  logic [NUM_LANES-1:0] mask_arr [NUM_REQ];
  logic [ROW_W-1:0]     data_arr [NUM_REQ];

  logic                 out_valid_reg, out_valid_next;
  logic [ADDR_W-1:0]    out_addr_reg, out_addr_next;
  logic [NUM_LANES-1:0] out_mask_reg, out_mask_next;
  logic [ROW_W-1:0]     out_data_reg, out_data_next;
  logic [IDX_W-1:0]     grant_id_reg, grant_id_next;
  logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;

  logic                 accept_ok;
  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  logic                 transfer;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign mask_arr[gi] = req_mask[gi*NUM_LANES +: NUM_LANES];
      assign data_arr[gi] = req_data[gi*ROW_W +: ROW_W];
    end
  endgenerate

  // The stage can take a new write when empty or when its current write
  // commits this cycle, which gives back-to-back throughput.
  assign accept_ok = !out_valid_reg || !wr_stall;

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign transfer = rst_n && accept_ok && grant_found;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = transfer && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    rr_ptr_next    = rr_ptr_reg;
    out_valid_next = out_valid_reg;
    out_addr_next  = out_addr_reg;
    out_mask_next  = out_mask_reg;
    out_data_next  = out_data_reg;
    grant_id_next  = grant_id_reg;
    if (transfer) begin
      rr_ptr_next    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      out_valid_next = 1'b1;
      out_addr_next  = addr_arr[grant_idx];
      out_mask_next  = mask_arr[grant_idx];
      out_data_next  = data_arr[grant_idx];
      grant_id_next  = grant_idx;
    end else if (out_valid_reg && !wr_stall) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      out_mask_reg  <= '0;
      out_data_reg  <= '0;
      grant_id_reg  <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_addr_reg  <= out_addr_next;
      out_mask_reg  <= out_mask_next;
      out_data_reg  <= out_data_next;
      grant_id_reg  <= grant_id_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

  assign write_en   = (out_valid_reg && !wr_stall) ? out_mask_reg : '0;
  assign waddr      = out_addr_reg;
  assign wdata      = out_data_reg;
  assign pend_valid = out_valid_reg;
  assign pend_addr  = out_addr_reg;
  assign grant_id   = grant_id_reg;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Randomized and directed bench for regbank_write_arbiter against a
// cycle-level reference model plus a register-bank image built from writes.
module tb_regbank_write_arbiter;

  localparam int NR   = 3;
  localparam int NL   = 8;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int RW   = NL * DW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*NL-1:0] req_mask;
  logic [NR*RW-1:0] req_data;
  logic             wr_stall;
  logic [NL-1:0]    write_en;
  logic [AW-1:0]    waddr;
  logic [RW-1:0]    wdata;
  logic             pend_valid;
  logic [AW-1:0]    pend_addr;
  logic [1:0]       grant_id;

  regbank_write_arbiter #(.NUM_REQ(NR), .NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
    .wr_stall(wr_stall),
    .write_en(write_en), .waddr(waddr), .wdata(wdata),
    .pend_valid(pend_valid), .pend_addr(pend_addr), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // requester side: each source holds one write until it is accepted
  bit            pv [NR];
  logic [AW-1:0] pa [NR];
  logic [NL-1:0] pm [NR];
  logic [RW-1:0] pd [NR];

  // reference model of the one-entry stage and round-robin pointer
  bit            m_ov;
  logic [AW-1:0] m_addr;
  logic [NL-1:0] m_mask;
  logic [RW-1:0] m_data;
  int            m_id;
  int            m_ptr;

  logic [DW-1:0] obs_bank [NREG][NL];
  logic [DW-1:0] ref_bank [NREG][NL];

  bit rst_drv;
  bit stall_drv;
  int obs_grant;
  int total = 0;
  int bad = 0;

  task automatic check_val(string tag, logic [RW-1:0] got, logic [RW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(int r, logic [AW-1:0] a, logic [NL-1:0] m, logic [DW-1:0] base, logic [DW-1:0] inc);
    pv[r] = 1'b1;
    pa[r] = a;
    pm[r] = m;
    for (int l = 0; l < NL; l++) pd[r][l*DW +: DW] = base + DW'(l) * inc;
  endtask

  // one clock cycle: drive at negedge, check combinational outputs, advance model
  task automatic step();
    int            exp_g;
    logic [NR-1:0] exp_ready;
    logic [NL-1:0] exp_we;
    @(negedge clk);
    rst_n    = rst_drv;
    wr_stall = stall_drv;
    for (int r = 0; r < NR; r++) begin
      req_valid[r]          = pv[r];
      req_addr[r*AW +: AW]  = pa[r];
      req_mask[r*NL +: NL]  = pm[r];
      req_data[r*RW +: RW]  = pd[r];
    end
    #1;
    exp_g = -1;
    if (rst_drv && (!m_ov || !stall_drv)) begin
      for (int k = 0; k < NR; k++) begin
        if (exp_g < 0 && pv[(m_ptr + k) % NR]) exp_g = (m_ptr + k) % NR;
      end
    end
    exp_ready = '0;
    if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
    exp_we = (m_ov && !stall_drv) ? m_mask : '0;

    check_val("req_ready", req_ready, exp_ready);
    check_val("write_en", write_en, exp_we);
    check_val("waddr", waddr, m_addr);
    check_val("wdata", wdata, m_data);
    check_val("pend_valid", pend_valid, m_ov);
    check_val("pend_addr", pend_addr, m_addr);
    check_val("grant_id", grant_id, m_id);

    obs_grant = -1;
    for (int r = 0; r < NR; r++) if (req_ready[r] === 1'b1) obs_grant = r;

    for (int l = 0; l < NL; l++) begin
      if (write_en[l] === 1'b1) obs_bank[waddr][l] = wdata[l*DW +: DW];
      if (exp_we[l]) ref_bank[m_addr][l] = m_data[l*DW +: DW];
    end

    if (!rst_drv) begin
      m_ov = 1'b0; m_addr = '0; m_mask = '0; m_data = '0; m_id = 0; m_ptr = 0;
    end else if (exp_g >= 0) begin
      m_ov   = 1'b1;
      m_addr = pa[exp_g];
      m_mask = pm[exp_g];
      m_data = pd[exp_g];
      m_id   = exp_g;
      m_ptr  = (exp_g + 1) % NR;
      pv[exp_g] = 1'b0;
    end else if (m_ov && !stall_drv) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pv[0] || pv[1] || pv[2] || m_ov) && n < 50) begin
      step();
      n++;
    end
    check_val("drain_bound", n < 50, 1'b1);
  endtask

  task automatic do_reset();
    rst_drv = 1'b0;
    step();
    rst_drv = 1'b1;
  endtask

  initial begin
    int wcount;
    rst_n = 1'b0; wr_stall = 1'b0;
    req_valid = '0; req_addr = '0; req_mask = '0; req_data = '0;
    rst_drv = 1'b0; stall_drv = 1'b0;
    m_ov = 1'b0; m_addr = '0; m_mask = '0; m_data = '0; m_id = 0; m_ptr = 0;
    for (int r = 0; r < NR; r++) begin pv[r] = 1'b0; pa[r] = '0; pm[r] = '0; pd[r] = '0; end
    for (int a = 0; a < NREG; a++)
      for (int l = 0; l < NL; l++) begin obs_bank[a][l] = '0; ref_bank[a][l] = '0; end

    // reset with every requester valid
    for (int r = 0; r < NR; r++) set_req(r, AW'(r + 1), 8'hFF, 32'h1000_0000 * (r + 1), 1);
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("rst_ready", req_ready, 3'b000);
      check_val("rst_we", write_en, 8'h00);
      check_val("rst_pend", pend_valid, 1'b0);
    end
    rst_drv = 1'b1;
    step();
    check_val("first_grant", obs_grant, 0);
    step();
    check_val("second_grant", obs_grant, 1);
    drain();

    // single write with one-cycle latency
    set_req(1, 5'h0A, 8'hFF, 32'hA000_0000, 1);
    step();
    check_val("t2_ready", req_ready, 3'b010);
    step();
    check_val("t2_we", write_en, 8'hFF);
    check_val("t2_waddr", waddr, 5'h0A);
    drain();
    for (int l = 0; l < NL; l++) check_val("t2_bank", obs_bank[10][l], 32'hA000_0000 + l);

    // fairness under continuous requests
    do_reset();
    wcount = 0;
    for (int i = 0; i < 13; i++) begin
      for (int r = 0; r < NR; r++)
        if (!pv[r]) set_req(r, AW'(16 + r), 8'hFF, 32'h3000_0000 + i * 256, 1);
      step();
      check_val("fair_seq", obs_grant, i % 3);
      if (i >= 1 && write_en == 8'hFF) wcount++;
    end
    check_val("throughput", wcount, 12);
    for (int r = 0; r < NR; r++) pv[r] = 1'b0;
    drain();

    // stall holds the stage and blocks grants
    set_req(0, 5'h11, 8'h0F, 32'hB000_0000, 1);
    step();
    stall_drv = 1'b1;
    set_req(2, 5'h12, 8'hFF, 32'hC000_0000, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("stall_we", write_en, 8'h00);
      check_val("stall_ready", req_ready, 3'b000);
      check_val("stall_pend", pend_valid, 1'b1);
      check_val("stall_addr", waddr, 5'h11);
    end
    stall_drv = 1'b0;
    step();
    check_val("unstall_we", write_en, 8'h0F);
    check_val("unstall_ready", req_ready, 3'b100);
    drain();

    // partial mask, then zero mask
    set_req(0, 5'd3, 8'hFF, 32'hD000_0000, 1);
    drain();
    set_req(1, 5'd3, 8'h81, 32'hE000_0000, 1);
    drain();
    for (int l = 0; l < NL; l++)
      check_val("pmask_bank", obs_bank[3][l], (l == 0 || l == 7) ? 32'hE000_0000 + l : 32'hD000_0000 + l);
    set_req(2, 5'd4, 8'h00, 32'hF000_0000, 1);
    step();
    step();
    check_val("zmask_pend", pend_valid, 1'b1);
    check_val("zmask_we", write_en, 8'h00);
    step();
    check_val("zmask_pend_clr", pend_valid, 1'b0);
    for (int l = 0; l < NL; l++) check_val("zmask_bank", obs_bank[4][l], 32'h0);

    // same-address writes commit in grant order
    do_reset();
    set_req(0, 5'd31, 8'hFF, 32'h1111_1111, 0);
    set_req(2, 5'd31, 8'hFF, 32'h2222_2222, 0);
    step();
    check_val("order_g0", obs_grant, 0);
    step();
    check_val("order_g2", obs_grant, 2);
    check_val("order_w0", wdata[31:0], 32'h1111_1111);
    drain();
    for (int l = 0; l < NL; l++) check_val("order_bank", obs_bank[31][l], 32'h2222_2222);

    // reset discards a pending write
    stall_drv = 1'b1;
    set_req(1, 5'd7, 8'hFF, 32'h7777_0000, 1);
    step();
    rst_drv = 1'b0;
    step();
    check_val("rstmid_we", write_en, 8'h00);
    rst_drv = 1'b1;
    stall_drv = 1'b0;
    step();
    check_val("rstmid_pend", pend_valid, 1'b0);
    check_val("rstmid_we2", write_en, 8'h00);
    drain();
    check_val("rstmid_bank", obs_bank[7][0], 32'h0);

    // randomized traffic with stalls and occasional resets
    for (int i = 0; i < 2000; i++) begin
      for (int r = 0; r < NR; r++)
        if (!pv[r] && $urandom_range(2) == 0)
          set_req(r, AW'($urandom), ($urandom_range(7) == 0) ? 8'h00 : NL'($urandom), $urandom, $urandom);
      stall_drv = ($urandom_range(3) == 0);
      rst_drv   = ($urandom_range(199) != 0);
      step();
    end
    rst_drv = 1'b1;
    stall_drv = 1'b0;
    drain();
    for (int a = 0; a < NREG; a++)
      for (int l = 0; l < NL; l++) check_val("bank_final", obs_bank[a][l], ref_bank[a][l]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of register_bank between NUM_REQ writeback sources, e.g. ALU writeback, load return and a config/debug path. Each source presents a full-warp write: address, lane mask and per-lane data. A one-entry output stage drives write_en/waddr/wdata_* of the bank, so the bank sees registered, glitch-free controls. A pending-write tap is exported for read-hazard checking by the issue logic.

Parameters:
NUM_REQ, 3, number of write requesters (2..8)
NUM_LANES, 8, SIMD lanes; matches register_bank write_en width
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, per-lane data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
req_addr  in  NUM_REQ*ADDR_W  requester r address at [r*ADDR_W +: ADDR_W]
req_mask  in  NUM_REQ*NUM_LANES  per-requester lane mask
req_data  in  NUM_REQ*NUM_LANES*DATA_W  requester r, lane l at [(r*NUM_LANES+l)*DATA_W +: DATA_W]
wr_stall  in  1  bank cannot accept a write this cycle; hold output stage
write_en  out  NUM_LANES  to register_bank write_en
waddr  out  ADDR_W  to register_bank waddr
wdata  out  NUM_LANES*DATA_W  lane l drives wdata_l, at [l*DATA_W +: DATA_W]
pend_valid  out  1  output stage holds a write not yet committed
pend_addr  out  ADDR_W  address of that write
grant_id  out  clog2(NUM_REQ)  index of the requester in the output stage

Behaviour:
- Reset (rst_n=0 at a rising edge): out_valid=0, out_addr=0, out_mask=0, out_data=0, rr_ptr=0. write_en=0, waddr=0, wdata=0, pend_valid=0, pend_addr=0, grant_id=0. req_ready=0 while rst_n=0, combinationally.
- Handshake: valid/ready. A transfer occurs when req_valid[r] and req_ready[r] are both high at a rising edge. A requester holds valid and payload stable until accepted. req_ready may depend combinationally on req_valid.
- accept_ok = !out_valid | !wr_stall. No grant is issued when accept_ok=0.
- Arbitration is round-robin. The search starts at rr_ptr and grants the first r with req_valid[r]=1, wrapping from NUM_REQ-1 to 0. At most one req_ready bit is high.
- On a transfer by r: rr_ptr <= (r+1) mod NUM_REQ. With no transfer, rr_ptr holds. Any requester waits at most NUM_REQ-1 grants.
- Output stage load on a transfer: out_valid<=1, out_addr<=req_addr[r], out_mask<=req_mask[r], out_data<=req_data[r], grant_id<=r.
- Drain: if out_valid and !wr_stall with no new transfer, out_valid<=0 at the edge. Drain and load in the same cycle is full throughput: one write per cycle.
- Outputs:
  - write_en = (out_valid & !wr_stall) ? out_mask : 0. This is combinational gating of registered state.
  - waddr = out_addr; wdata = out_data.
  - pend_valid = out_valid; pend_addr = out_addr.
- Latency: a request granted in cycle N has write_en asserted in cycle N+1. The bank commits it at the end of N+1, so data is readable from cycle N+2.
- A zero lane mask is accepted normally and occupies the output stage for one cycle. write_en stays 0 throughout.
- wr_stall held high: the stage keeps its contents, write_en=0, and no new grants are issued. Requests stay pending.
- Duplicate addresses from different requesters are written in grant order. No merging occurs.
- Reset mid-operation: an in-flight output-stage write is discarded and write_en drops at the reset edge. Requesters must re-present after reset.
- Synthesis constraint: no latches. Mux widths derive from parameters only.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, write_en=8'h00, pend_valid=0. After release, the first grant goes to r0 and rr_ptr becomes 1.
2. Single write: r1 sends addr=5'h0A, mask=8'hFF, lane l data=32'hA000_0000+l in cycle N -> write_en=8'hFF, waddr=5'h0A in N+1. Port-0 reads of reg 10 from N+2 return the lane data.
3. Fairness: all 3 requesters continuously valid, wr_stall=0 -> grant sequence 0,1,2,0,1,2..., one write per cycle, no bubbles.
4. Stall: hold wr_stall=1 for 4 cycles with r2 pending -> output contents frozen, write_en=0 and req_ready=0 each cycle. write_en pulses in the first cycle with wr_stall=0.
5. Partial mask and zero mask: mask=8'h81 to reg 3 -> only lanes 0 and 7 change and other lanes keep prior values. mask=8'h00 -> bank unchanged, pend_valid=1 for one cycle.
6. Ordering: r0 writes 32'h1111_1111 and r2 writes 32'h2222_2222 to reg 31 in the same cycle -> r0 is committed first, and the final read returns 32'h2222_2222 on all lanes. Then assert reset while a write is pending -> no write occurs.
